// File: rtl/wb_pkg.sv
// Shared encodings for the write-back data pipe.
// Holds the extension mode codes and the skid buffer state type.
package wb_pkg;

    localparam logic [1:0] EXT_WORD   = 2'b00;
    localparam logic [1:0] EXT_HALF_Z = 2'b01;
    localparam logic [1:0] EXT_BYTE_Z = 2'b10;
    localparam logic [1:0] EXT_BYTE_S = 2'b11;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_extend.sv
// Width extension of a selected load source.
// Half and byte modes take the low bits and fill upward.
module wb_extend
    import wb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        unique case (i_mode)
            EXT_WORD:   o_data = i_data;
            EXT_HALF_Z: o_data = {{(WIDTH-16){1'b0}}, i_data[15:0]};
            EXT_BYTE_Z: o_data = {{(WIDTH-8){1'b0}}, i_data[7:0]};
            EXT_BYTE_S: o_data = {{(WIDTH-8){i_data[7]}}, i_data[7:0]};
            default:    o_data = i_data;
        endcase
    end

endmodule

// File: rtl/wb_data_pipe.sv
// Write-back source select and extend, behind a 2-entry skid buffer.
// in_ready is registered so out_ready never reaches it combinationally.
module wb_data_pipe
    import wb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_IN  = 8,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic [1:0]            ext_mode,
    input  logic [N_IN*WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      data_out,
    output logic                  sel_err
);

    localparam int             IDX_W = $clog2(N_IN*WIDTH);
    localparam logic [SEL_W:0] LP_N  = (SEL_W+1)'(N_IN);

    wb_state_e          r_state;
    wb_state_e          w_state_nxt;
    logic               r_in_ready;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_err;
    logic [WIDTH-1:0]   r_skid_data;
    logic               r_skid_err;

    logic               w_sel_ok;
    logic [SEL_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_base;
    logic [WIDTH-1:0]   w_src;
    logic [WIDTH-1:0]   w_ext;
    logic [WIDTH-1:0]   w_res;
    logic               w_err;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic               w_load_out;
    logic               w_skid_to_out;
    logic               w_load_skid;

    // Out-of-range selects are clamped so the part-select never leaves data_in.
    assign w_sel_ok = {1'b0, sel} < LP_N;
    assign w_idx    = w_sel_ok ? sel : '0;
    assign w_base   = IDX_W'(w_idx) * IDX_W'(WIDTH);
    assign w_src    = data_in[w_base +: WIDTH];

    wb_extend #(
        .WIDTH (WIDTH)
    ) u_extend (
        .i_data (w_src),
        .i_mode (ext_mode),
        .o_data (w_ext)
    );

    assign w_res = w_sel_ok ? w_ext : '0;
    assign w_err = ~w_sel_ok;

    assign out_valid  = (r_state != EMPTY);
    assign in_ready   = r_in_ready;
    assign data_out   = r_out_data;
    assign sel_err    = r_out_err;
    assign w_in_xfer  = in_valid & r_in_ready;
    assign w_out_xfer = out_valid & out_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_load_out    = 1'b0;
        w_skid_to_out = 1'b0;
        w_load_skid   = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = ONE;
                    w_load_out  = 1'b1;
                end
            end
            ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_out = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_nxt = TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (w_out_xfer) begin
                    w_state_nxt   = ONE;
                    w_skid_to_out = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_data  <= '0;
            r_out_err   <= 1'b0;
            r_skid_data <= '0;
            r_skid_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != TWO);
            if (w_load_out) begin
                r_out_data <= w_res;
                r_out_err  <= w_err;
            end else if (w_skid_to_out) begin
                r_out_data <= r_skid_data;
                r_out_err  <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_data <= w_res;
                r_skid_err  <= w_err;
            end
        end
    end

endmodule

// File: tb/tb_wb_data_pipe.sv
// Bench for wb_data_pipe: queue model on a 16-source instance
// plus directed out-of-range checks on a 6-source instance.
module tb_wb_data_pipe;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } ent_t;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   sel;
    logic [1:0]   ext_mode;
    logic [511:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  data_out;
    logic         sel_err;

    logic         v6;
    logic         rdy6;
    logic [2:0]   sel6;
    logic [1:0]   mode6;
    logic [191:0] data6;
    logic         ov6;
    logic         ordy6;
    logic [31:0]  do6;
    logic         err6;

    int   n_chk = 0;
    int   n_err = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    wb_data_pipe #(.WIDTH(32), .N_IN(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .ext_mode  (ext_mode),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .sel_err   (sel_err)
    );

    wb_data_pipe #(.WIDTH(32), .N_IN(6)) dut6 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (v6),
        .in_ready  (rdy6),
        .sel       (sel6),
        .ext_mode  (mode6),
        .data_in   (data6),
        .out_valid (ov6),
        .out_ready (ordy6),
        .data_out  (do6),
        .sel_err   (err6)
    );

    function automatic ent_t expect_of(input int s, input logic [1:0] m);
        ent_t r;
        logic [31:0] w;
        r.e = (s >= 16);
        w = r.e ? 32'h0 : data_in[s*32 +: 32];
        case (m)
            2'd0:    r.d = w;
            2'd1:    r.d = w & 32'h0000_FFFF;
            2'd2:    r.d = w & 32'h0000_00FF;
            default: r.d = w[7] ? (w | 32'hFFFF_FF00) : (w & 32'h0000_00FF);
        endcase
        if (r.e) r.d = 32'h0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() != 0) begin
            chk("data_out", data_out, q[0].d);
            chk("sel_err", 32'(sel_err), 32'(q[0].e));
        end
    endtask

    // Called at a falling edge; applies inputs, crosses one rising edge, checks.
    task automatic step(input logic v, input int s, input logic [1:0] m, input logic ordy);
        bit   ox;
        bit   ix;
        ent_t e;
        in_valid  = v;
        sel       = 4'(s);
        ext_mode  = m;
        out_ready = ordy;
        ox = (q.size() > 0) && ordy;
        ix = v && (q.size() < 2);
        e  = expect_of(s, m);
        @(posedge clk);
        if (ox) void'(q.pop_front());
        if (ix) q.push_back(e);
        #1;
        in_valid = 1'($urandom);
        sel      = 4'($urandom);
        ext_mode = 2'($urandom);
        @(negedge clk);
        compare();
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        sel       = '0;
        ext_mode  = '0;
        out_ready = 1'b0;
        data_in   = '0;
        v6        = 1'b0;
        sel6      = '0;
        mode6     = '0;
        ordy6     = 1'b1;
        data6     = {6{32'hDEAD_BEEF}};

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_sel_err", 32'(sel_err), 32'h0);
        reset_n = 1'b1;

        data_in[5*32 +: 32] = 32'h1234_F0A5;
        step(1'b1, 5, 2'b11, 1'b1);
        chk("ext_byte_s", data_out, 32'hFFFF_FFA5);
        step(1'b1, 5, 2'b01, 1'b1);
        chk("ext_half_z", data_out, 32'h0000_F0A5);
        step(1'b1, 5, 2'b00, 1'b1);
        chk("ext_word", data_out, 32'h1234_F0A5);
        step(1'b1, 5, 2'b10, 1'b1);
        chk("ext_byte_z", data_out, 32'h0000_00A5);
        step(1'b0, 0, 2'b00, 1'b1);

        data_in[1*32 +: 32] = 32'hAAAA_0001;
        data_in[2*32 +: 32] = 32'hBBBB_0002;
        data_in[3*32 +: 32] = 32'hCCCC_0083;
        step(1'b1, 1, 2'b00, 1'b0);
        step(1'b1, 2, 2'b00, 1'b0);
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        chk("bp_hold_a", data_out, 32'hAAAA_0001);
        step(1'b1, 3, 2'b00, 1'b0);
        chk("bp_ignore", data_out, 32'hAAAA_0001);
        step(1'b0, 0, 2'b00, 1'b1);
        chk("bp_then_b", data_out, 32'hBBBB_0002);
        chk("bp_ready_back", 32'(in_ready), 32'h1);
        step(1'b0, 0, 2'b00, 1'b1);
        chk("bp_drained", 32'(out_valid), 32'h0);

        step(1'b1, 1, 2'b00, 1'b0);
        step(1'b1, 2, 2'b00, 1'b1);
        chk("simul_new", data_out, 32'hBBBB_0002);
        step(1'b0, 0, 2'b00, 1'b1);

        for (int i = 0; i < 16; i++) data_in[i*32 +: 32] = 32'h5000_0000 + 32'(i * 32'h0101);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i, 2'b00, 1'b1);
            chk("tp_order", data_out, 32'h5000_0000 + 32'(i * 32'h0101));
        end
        step(1'b0, 0, 2'b00, 1'b1);

        step(1'b1, 1, 2'b00, 1'b0);
        step(1'b1, 2, 2'b00, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_in_ready", 32'(in_ready), 32'h1);
        chk("arst_data_out", data_out, 32'h0);
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        data_in[3*32 +: 32] = 32'hCCCC_0083;
        step(1'b1, 3, 2'b11, 1'b1);
        chk("post_rst_first", data_out, 32'hFFFF_FF83);
        step(1'b0, 0, 2'b00, 1'b1);

        data6[0 +: 32] = 32'hCAFE_0001;
        v6 = 1'b1; sel6 = 3'd7; mode6 = 2'b00;
        step(1'b0, 0, 2'b00, 1'b1);
        chk("oor7_valid", 32'(ov6), 32'h1);
        chk("oor7_data", do6, 32'h0);
        chk("oor7_err", 32'(err6), 32'h1);
        sel6 = 3'd0;
        step(1'b0, 0, 2'b00, 1'b1);
        chk("oor_clear_err", 32'(err6), 32'h0);
        chk("oor_clear_data", do6, 32'hCAFE_0001);
        sel6 = 3'd6;
        step(1'b0, 0, 2'b00, 1'b1);
        chk("oor6_err", 32'(err6), 32'h1);
        sel6 = 3'd5; mode6 = 2'b11;
        step(1'b0, 0, 2'b00, 1'b1);
        chk("last_src_err", 32'(err6), 32'h0);
        chk("last_src_data", do6, 32'hFFFF_FFEF);
        v6 = 1'b0;
        step(1'b0, 0, 2'b00, 1'b1);
        chk("u6_ready", 32'(rdy6), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_data_pipe.md
WB_DATA_PIPE -- requirements
Module: wb_data_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width of each source and of the result.
REQ-002 SHALL have parameter N_IN, default 8, meaning number of selectable sources (2..16).
REQ-003 SHALL have parameter SEL_W, default $clog2(N_IN), meaning select field width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state SHALL be updated on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, meaning reset; asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, meaning the upstream request is present.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts a request this cycle.
REQ-008 SHALL have port sel, input, SEL_W, meaning binary source index (MemToReg generalised).
REQ-009 SHALL have port ext_mode, input, 2, meaning 00 word, 01 half zero-ext, 10 byte zero-ext, 11 byte sign-ext.
REQ-010 SHALL have port data_in, input, N_IN*WIDTH, meaning flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
REQ-011 SHALL have port out_valid, output, 1, meaning data_out holds a result.
REQ-012 SHALL have port out_ready, input, 1, meaning the downstream consumes the result.
REQ-013 SHALL have port data_out, output, WIDTH, meaning selected and extended result.
REQ-014 SHALL have port sel_err, output, 1, meaning the current result came from sel >= N_IN.

Function
REQ-015 Transfer in: in_valid && in_ready on a rising edge; transfer out: out_valid && out_ready on a rising edge.
REQ-016 Result = ext(source[sel], ext_mode): half = bits[15:0], byte = bits[7:0]; zero- or sign-fill to WIDTH; word = unchanged.
REQ-017 sel >= N_IN SHALL yield data_out = 0 with sel_err = 1 for that result only; no sticky state.
REQ-018 Latency SHALL be exactly 1 cycle: an accepted request appears on data_out/out_valid the next cycle when the output stage is empty or draining.
REQ-019 Buffering SHALL be a 2-entry skid (output register + skid register); states EMPTY, ONE, TWO.
REQ-020 EMPTY: in transfer -> ONE; else stay.
REQ-021 ONE: in transfer without out transfer -> TWO; out transfer without in transfer -> EMPTY; both or neither -> ONE (on both, output register loads the new result).
REQ-022 TWO: out transfer -> ONE, skid moves to output register; in transfer impossible.
REQ-023 in_ready SHALL be a registered signal equal to (state != TWO); no combinational path from out_ready to in_ready.
REQ-024 out_valid SHALL equal (state != EMPTY); data_out and sel_err SHALL be stable while out_valid && !out_ready.
REQ-025 Full throughput: with out_ready held 1, one result per cycle, never entering TWO.
REQ-026 in_valid while in_ready = 0 SHALL be ignored; inputs SHALL not need to be held stable.

Reset
REQ-027 reset_n low SHALL asynchronously force state EMPTY, out_valid 0, in_ready 1, data_out 0, sel_err 0, skid contents 0.
REQ-028 Reset asserted mid-transfer SHALL discard both buffered entries; first accept after deassertion follows REQ-018.
REQ-029 Deassertion SHALL be synchronised externally; the block applies no reset synchroniser.

Structure
REQ-030 Package wb_pkg SHALL hold the ext_mode encodings and the state enum (EMPTY, ONE, TWO).
REQ-031 Sub-module wb_extend (combinational, WIDTH parameter) SHALL implement REQ-016; instantiated once ahead of the registers.
REQ-032 Select SHALL be an indexed part-select over data_in, no per-source hard-coded tree.

Verification
REQ-033 Reset: reset_n=0 asynchronously mid-cycle with TWO held -> out_valid=0, in_ready=1, data_out=0 before next edge.
REQ-034 Select/extend: N_IN=8, source 5 = 0x1234_F0A5, sel=5, mode 11 -> data_out=0xFFFF_FFA5 one cycle later; mode 01 -> 0x0000_F0A5; mode 00 -> 0x1234_F0A5.
REQ-035 Out of range: N_IN=6, sel=7 -> data_out=0, sel_err=1; next request sel=0 -> sel_err=0.
REQ-036 Backpressure: out_ready=0, send results A, B -> state TWO, in_ready=0, data_out=A stable; third request ignored; out_ready=1 -> A then B on consecutive cycles, in_ready=1.
REQ-037 Throughput: out_ready=1, 16 back-to-back requests sel=0..15 (N_IN=16) -> 16 results on 16 consecutive cycles, in order, in_ready never 0.
REQ-038 Simultaneous: in ONE, in and out transfer same edge -> state ONE, data_out = new result next cycle.
